// File: rtl/radix_4_intt_pipe.sv
`default_nettype none
// ============================================================================
// Module   : radix_4_intt_pipe
// Brief    : Three-stage pipelined radix-4 Gentleman-Sande inverse butterfly.
//            Butterfly first, then the x(-j) rotation, then twiddle multiply.
//            Valid/ready handshake with collapsing bubbles, 1 group/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module radix_4_intt_pipe #(
  parameter int WIDTH = 16,
  parameter int Q     = 12289,
  parameter int IMAG  = 1479
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic [WIDTH-1:0] input_3,
  input  logic [WIDTH-1:0] input_4,
  input  logic [WIDTH-1:0] input_twiddle_1,
  input  logic [WIDTH-1:0] input_twiddle_2,
  input  logic [WIDTH-1:0] input_twiddle_3,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_1,
  output logic [WIDTH-1:0] output_2,
  output logic [WIDTH-1:0] output_3,
  output logic [WIDTH-1:0] output_4,
  output logic             out_last
);

  localparam logic [WIDTH-1:0]   c_q   = WIDTH'(Q);
  localparam logic [WIDTH-1:0]   c_ji  = WIDTH'(Q - IMAG);
  localparam logic [2*WIDTH-1:0] c_q2  = (2*WIDTH)'(Q);
  localparam logic [2*WIDTH:0]   c_pow = {1'b1, {(2*WIDTH){1'b0}}};
  // Barrett factor floor(2^(2*WIDTH)/Q); always fits 2*WIDTH bits for Q > 1
  localparam logic [2*WIDTH-1:0] c_bm  = (2*WIDTH)'(c_pow / (2*WIDTH+1)'(Q));

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, c_q}) sum = sum - {1'b0, c_q};
    return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[WIDTH]) diff = diff + {1'b0, c_q};
    return diff[WIDTH-1:0];
  endfunction

  // Barrett estimate is at most 2 short of the true quotient, so the
  // remainder lands below 3Q and two conditional subtractions finish it.
  function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    logic [4*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] qe;
    logic [2*WIDTH-1:0] r;
    p    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    prod = {{(2*WIDTH){1'b0}}, p} * {{(2*WIDTH){1'b0}}, c_bm};
    qe   = (2*WIDTH)'(prod >> (2*WIDTH));
    r    = p - qe * c_q2;
    if (r >= c_q2) r = r - c_q2;
    if (r >= c_q2) r = r - c_q2;
    return r[WIDTH-1:0];
  endfunction

  // Pipeline state
  logic             v1_q, v2_q, v3_q;
  logic             v1_d, v2_d, v3_d;
  logic             ld1, ld2, ld3;
  logic [WIDTH-1:0] st1_s0_q, st1_s1_q, st1_s2_q, st1_d3_q;
  logic [WIDTH-1:0] st1_w1_q, st1_w2_q, st1_w3_q;
  logic             st1_last_q;
  logic [WIDTH-1:0] st2_s0_q, st2_s1_q, st2_s2_q, st2_s3_q;
  logic [WIDTH-1:0] st2_w1_q, st2_w2_q, st2_w3_q;
  logic             st2_last_q;
  logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q;
  logic             last_q;
  logic [WIDTH-1:0] st1_s0_d, st1_s1_d, st1_s2_d, st1_d3_d;
  logic [WIDTH-1:0] st2_s3_d;
  logic [WIDTH-1:0] y0_d, y1_d, y2_d, y3_d;

  // Handshake: a stage loads when empty or when its content moves on,
  // so the ready chain ripples back from out_ready and bubbles collapse.
  always_comb begin
    ld3  = !v3_q || out_ready;
    ld2  = !v2_q || ld3;
    ld1  = !v1_q || ld2;
    v1_d = ld1 ? in_valid : v1_q;
    v2_d = ld2 ? v1_q     : v2_q;
    v3_d = ld3 ? v2_q     : v3_q;
  end

  assign in_ready = ld1;

  // Datapath next values for the three stages
  always_comb begin
    st1_s0_d = mod_add(input_1, input_3);
    st1_s1_d = mod_sub(input_1, input_3);
    st1_s2_d = mod_add(input_2, input_4);
    st1_d3_d = mod_sub(input_2, input_4);
    st2_s3_d = mod_mul(st1_d3_q, c_ji);
    y0_d     = mod_add(st2_s0_q, st2_s2_q);
    y1_d     = mod_mul(mod_add(st2_s1_q, st2_s3_q), st2_w1_q);
    y2_d     = mod_mul(mod_sub(st2_s0_q, st2_s2_q), st2_w2_q);
    y3_d     = mod_mul(mod_sub(st2_s1_q, st2_s3_q), st2_w3_q);
  end

  // Valid bits; cleared at once by reset so in-flight groups are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  // Data registers; each stage captures only when a valid group enters it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1_s0_q <= '0; st1_s1_q <= '0; st1_s2_q <= '0; st1_d3_q <= '0;
      st1_w1_q <= '0; st1_w2_q <= '0; st1_w3_q <= '0; st1_last_q <= 1'b0;
      st2_s0_q <= '0; st2_s1_q <= '0; st2_s2_q <= '0; st2_s3_q <= '0;
      st2_w1_q <= '0; st2_w2_q <= '0; st2_w3_q <= '0; st2_last_q <= 1'b0;
      y0_q     <= '0; y1_q     <= '0; y2_q     <= '0; y3_q     <= '0;
      last_q   <= 1'b0;
    end else begin
      if (ld1 && in_valid) begin
        st1_s0_q   <= st1_s0_d;
        st1_s1_q   <= st1_s1_d;
        st1_s2_q   <= st1_s2_d;
        st1_d3_q   <= st1_d3_d;
        st1_w1_q   <= input_twiddle_1;
        st1_w2_q   <= input_twiddle_2;
        st1_w3_q   <= input_twiddle_3;
        st1_last_q <= in_last;
      end
      if (ld2 && v1_q) begin
        st2_s0_q   <= st1_s0_q;
        st2_s1_q   <= st1_s1_q;
        st2_s2_q   <= st1_s2_q;
        st2_s3_q   <= st2_s3_d;
        st2_w1_q   <= st1_w1_q;
        st2_w2_q   <= st1_w2_q;
        st2_w3_q   <= st1_w3_q;
        st2_last_q <= st1_last_q;
      end
      if (ld3 && v2_q) begin
        y0_q   <= y0_d;
        y1_q   <= y1_d;
        y2_q   <= y2_d;
        y3_q   <= y3_d;
        last_q <= st2_last_q;
      end
    end
  end

  assign out_valid = v3_q;
  assign output_1  = y0_q;
  assign output_2  = y1_q;
  assign output_3  = y2_q;
  assign output_4  = y3_q;
  assign out_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_radix_4_intt_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_radix_4_intt_pipe
// Brief    : Self-checking bench: modular-arithmetic reference model with an
//            in-order scoreboard, plus directed literal vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radix_4_intt_pipe;

  localparam int W  = 16;
  localparam int Q  = 12289;
  localparam int JI = 10810;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a0, a1, a2, a3, w1, w2, w3;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y0, y1, y2, y3;
  logic         out_last;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;
  logic [4*W:0] exp_q[$];

  radix_4_intt_pipe dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .input_1         (a0),
    .input_2         (a1),
    .input_3         (a2),
    .input_4         (a3),
    .input_twiddle_1 (w1),
    .input_twiddle_2 (w2),
    .input_twiddle_3 (w3),
    .in_last         (in_last),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .output_1        (y0),
    .output_2        (y1),
    .output_3        (y2),
    .output_4        (y3),
    .out_last        (out_last)
  );

  always #5 clk = ~clk;

  // Reference: the inverse butterfly in plain integer arithmetic mod Q
  function automatic logic [4*W-1:0] ref_y(input longint x0, input longint x1,
                                           input longint x2, input longint x3,
                                           input longint t1, input longint t2,
                                           input longint t3);
    longint s0, s1, s2, s3, r0, r1, r2, r3;
    s0 = (x0 + x2) % Q;
    s1 = (x0 - x2 + Q) % Q;
    s2 = (x1 + x3) % Q;
    s3 = (((x1 - x3 + Q) % Q) * JI) % Q;
    r0 = (s0 + s2) % Q;
    r1 = (((s1 + s3) % Q) * t1) % Q;
    r2 = (((s0 - s2 + Q) % Q) * t2) % Q;
    r3 = (((s1 - s3 + Q) % Q) * t3) % Q;
    return {W'(r0), W'(r1), W'(r2), W'(r3)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle with out_valid, the outputs must equal the oldest
  // outstanding group; this also proves stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          check("sb_y0",   64'(y0),       64'(exp_q[0][4*W-1:3*W]));
          check("sb_y1",   64'(y1),       64'(exp_q[0][3*W-1:2*W]));
          check("sb_y2",   64'(y2),       64'(exp_q[0][2*W-1:W]));
          check("sb_y3",   64'(y3),       64'(exp_q[0][W-1:0]));
          check("sb_last", 64'(out_last), 64'(exp_q[0][4*W]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_last, ref_y(a0, a1, a2, a3, w1, w2, w3)});
    end
  end

  // Pseudo-random downstream stall generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic push(input int x0, input int x1, input int x2, input int x3,
                      input int t1, input int t2, input int t3, input bit last);
    bit ok;
    ok = 1'b0;
    a0 = W'(x0); a1 = W'(x1); a2 = W'(x2); a3 = W'(x3);
    w1 = W'(t1); w2 = W'(t2); w3 = W'(t3);
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) check("push_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic expect_y(input string name, input int e0, input int e1,
                          input int e2, input int e3);
    check({name, "_y0"}, 64'(y0), 64'(e0));
    check({name, "_y1"}, 64'(y1), 64'(e1));
    check({name, "_y2"}, 64'(y2), 64'(e2));
    check({name, "_y3"}, 64'(y3), 64'(e3));
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin done = 1'b1; break; end
    end
    if (!done) check({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  int acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0; w1 = '0; w2 = '0; w3 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    expect_y("rst", 0, 0, 0, 0);
    check("rst_out_last", 64'(out_last), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Impulse with exact 3-cycle latency
    push(1, 0, 0, 0, 1, 1, 1, 1'b1);
    @(negedge clk); check("lat_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_cycle2", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_cycle3", 64'(out_valid), 64'd1);
    expect_y("impulse", 1, 1, 1, 1);
    check("impulse_last", 64'(out_last), 64'd1);
    wait_drain("impulse");

    // Imaginary-unit path
    push(0, 1, 0, 0, 1, 1, 1, 1'b0);
    wait_out("imag");
    expect_y("imag", 1, 10810, 12288, 1479);
    wait_drain("imag");

    // Maximum-coefficient boundary
    push(12288, 12288, 12288, 12288, 1, 1, 1, 1'b0);
    wait_out("bound");
    expect_y("bound", 12285, 0, 0, 0);
    wait_drain("bound");

    // Twiddle path including w = Q-1
    push(5, 0, 0, 0, 2, 3, 12288, 1'b1);
    wait_out("twid");
    expect_y("twid", 5, 10, 15, 12284);
    wait_drain("twid");

    // Random stream under random backpressure
    rand_ready = 1'b1;
    for (int g = 0; g < 8; g++)
      push($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1),
           $urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1),
           $urandom_range(0, Q-1), 1'((g % 3) == 0));
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("stream");

    // Full pipe: exactly three accepted with out_ready low
    out_ready = 1'b0;
    acc = 0;
    for (int g = 0; g < 4; g++) begin
      a0 = W'(10 + g); a1 = W'(20 + g); a2 = W'(30 + g); a3 = W'(40 + g);
      w1 = W'(g + 2); w2 = W'(g + 3); w3 = W'(g + 4);
      in_last = 1'(g & 1);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    check("full_accept_count", 64'(acc), 64'd3);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("poppush_in_ready", 64'(in_ready), 64'd1);
    check("poppush_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("poppush_still_full", 64'(out_valid), 64'd1);
    check("poppush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("full");

    // Asynchronous reset with the pipe full
    out_ready = 1'b0;
    push(100, 200, 300, 400, 5, 6, 7, 1'b1);
    push(1, 1, 1, 1, 1, 1, 1, 1'b1);
    push(7, 8, 9, 10, 11, 12, 13, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    expect_y("arst", 0, 0, 0, 0);
    check("arst_out_last", 64'(out_last), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    push(1, 2, 3, 4, 5, 6, 7, 1'b0);
    @(negedge clk); check("post_rst_lat1", 64'(out_valid), 64'd0);
    @(negedge clk); check("post_rst_lat2", 64'(out_valid), 64'd0);
    @(negedge clk); check("post_rst_lat3", 64'(out_valid), 64'd1);
    expect_y("post_rst", 10, 2491, 12277, 3858);
    wait_drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
